// File: rtl/bypass_track_if.sv
// rtl/bypass_track_if.sv - issue/compare/select bundle for the bypass tracker
//
// Purpose: groups the issue, stall/squash, source-compare and bypass-select
// signals of bypass_track so they travel as one port.
// Signals:
//   IssueDest_s1  per-slot {valid, spec} destinations entering stage 0
//   Advance_s1    1 = pipeline moves one stage, 0 = hold
//   Squash_s1     per-stage invalidate of the next state
//   SrcSpec_s1    per-source specifiers to compare
//   SrcValid_s1   per-source request valid
//   BypassSel_v2  registered one-hot select per source
//   BypassHit_v2  registered per-source hit flag
// Modports: master drives requests, slave is the tracker.
interface bypass_track_if #(
  parameter int SPEC_W = 6,
  parameter int NSLOT  = 2,
  parameter int NSTAGE = 2,
  parameter int NSRC   = 4
);
  logic [NSLOT*(SPEC_W+1)-1:0]         IssueDest_s1;
  logic                                Advance_s1;
  logic [NSTAGE-1:0]                   Squash_s1;
  logic [NSRC*SPEC_W-1:0]              SrcSpec_s1;
  logic [NSRC-1:0]                     SrcValid_s1;
  logic [NSRC*(NSLOT*NSTAGE+1)-1:0]    BypassSel_v2;
  logic [NSRC-1:0]                     BypassHit_v2;

  modport master (
    output IssueDest_s1, Advance_s1, Squash_s1, SrcSpec_s1, SrcValid_s1,
    input  BypassSel_v2, BypassHit_v2
  );

  modport slave (
    input  IssueDest_s1, Advance_s1, Squash_s1, SrcSpec_s1, SrcValid_s1,
    output BypassSel_v2, BypassHit_v2
  );
endinterface

// File: rtl/bypass_track.sv
// rtl/bypass_track.sv - in-flight destination pipeline with registered bypass select
//
// Purpose: tracks destination specifiers of every issue slot through NSTAGE
// stages and compares each source specifier against all valid in-flight
// destinations, producing a registered one-hot bypass select per source.
// Ports:
//   Phi1   clock, rising edge
//   Reset  asynchronous active-high reset
//   bus    bypass_track_if.slave (issue, advance, squash, sources, selects)
// Select field per source: bit 0 = no bypass, bit 1+k*NSLOT+s = stage k slot s.
module bypass_track #(
  parameter int SPEC_W = 6,
  parameter int NSLOT  = 2,
  parameter int NSTAGE = 2,
  parameter int NSRC   = 4
) (
  input  logic           Phi1,
  input  logic           Reset,
  bypass_track_if.slave  bus
);

  localparam int DW = SPEC_W + 1;
  localparam int FW = NSLOT * NSTAGE + 1;

  logic              destValid [NSTAGE][NSLOT];
  logic [SPEC_W-1:0] destSpec  [NSTAGE][NSLOT];

  // Value each stage would take on an advance: stage 0 from issue, others
  // from the stage in front of them.
  logic              inValid [NSTAGE][NSLOT];
  logic [SPEC_W-1:0] inSpec  [NSTAGE][NSLOT];

  for (genvar k = 0; k < NSTAGE; k++) begin : gStageIn
    for (genvar s = 0; s < NSLOT; s++) begin : gSlotIn
      if (k == 0) begin : gIssue
        assign inValid[k][s] = bus.IssueDest_s1[s*DW + SPEC_W];
        assign inSpec[k][s]  = bus.IssueDest_s1[s*DW +: SPEC_W];
      end else begin : gShift
        assign inValid[k][s] = destValid[k-1][s];
        assign inSpec[k][s]  = destSpec[k-1][s];
      end
    end
  end

  always_ff @(posedge Phi1 or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        for (int s = 0; s < NSLOT; s++) begin
          destValid[k][s] <= 1'b0;
          destSpec[k][s]  <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        for (int s = 0; s < NSLOT; s++) begin
          // Specs load regardless of valid; only the valid bit is squashed.
          if (bus.Advance_s1) begin
            destSpec[k][s] <= inSpec[k][s];
          end
          if (bus.Squash_s1[k]) begin
            destValid[k][s] <= 1'b0;
          end else if (bus.Advance_s1) begin
            destValid[k][s] <= inValid[k][s];
          end
        end
      end
    end
  end

  logic [NSRC*FW-1:0] selNext;
  logic [NSRC-1:0]    hitNext;
  logic [FW-1:0]      field;
  logic [SPEC_W-1:0]  src;

  // Scan oldest stage first and lowest slot first so that later matches
  // overwrite earlier ones: youngest stage wins, then highest slot.
  always_comb begin
    selNext = '0;
    hitNext = '0;
    field   = '0;
    src     = '0;
    for (int i = 0; i < NSRC; i++) begin
      field = FW'(1);
      src   = bus.SrcSpec_s1[i*SPEC_W +: SPEC_W];
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        for (int s = 0; s < NSLOT; s++) begin
          if (bus.SrcValid_s1[i] && (src != '0) && destValid[k][s] &&
              (destSpec[k][s] == src)) begin
            field = FW'(1) << (1 + k*NSLOT + s);
          end
        end
      end
      selNext[i*FW +: FW] = field;
      hitNext[i]          = ~field[0];
    end
  end

  logic [NSRC*FW-1:0] selReg;
  logic [NSRC-1:0]    hitReg;

  always_ff @(posedge Phi1 or posedge Reset) begin
    if (Reset) begin
      selReg <= {NSRC{FW'(1)}};
      hitReg <= '0;
    end else begin
      selReg <= selNext;
      hitReg <= hitNext;
    end
  end

  assign bus.BypassSel_v2 = selReg;
  assign bus.BypassHit_v2 = hitReg;

endmodule

// File: tb/tb_bypass_track.sv
// tb/tb_bypass_track.sv - self-checking bench for bypass_track
module tb_bypass_track;

  localparam int SPEC_W = 6;
  localparam int NSLOT  = 2;
  localparam int NSTAGE = 2;
  localparam int NSRC   = 4;
  localparam int DW     = SPEC_W + 1;
  localparam int FW     = NSLOT * NSTAGE + 1;

  typedef logic [NSLOT*DW-1:0] grp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chkEn  = 1'b0;

  bypass_track_if #(.SPEC_W(SPEC_W), .NSLOT(NSLOT), .NSTAGE(NSTAGE), .NSRC(NSRC)) bus ();

  bypass_track #(.SPEC_W(SPEC_W), .NSLOT(NSLOT), .NSTAGE(NSTAGE), .NSRC(NSRC)) dut (
    .Phi1  (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a queue of issue groups, youngest at the front.
  grp_t              pipe[$];
  logic [NSRC*FW-1:0] expSel;
  logic [NSRC-1:0]    expHit;

  function automatic int findSrc(int i);
    logic [SPEC_W-1:0] sp;
    grp_t g;
    sp = bus.SrcSpec_s1[i*SPEC_W +: SPEC_W];
    if (!bus.SrcValid_s1[i] || sp == 0) return 0;
    for (int k = 0; k < NSTAGE; k++) begin
      g = pipe[k];
      for (int s = NSLOT - 1; s >= 0; s--) begin
        if (g[s*DW + SPEC_W] && g[s*DW +: SPEC_W] == sp) return 1 + k*NSLOT + s;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe = {};
      for (int k = 0; k < NSTAGE; k++) pipe.push_back('0);
      expSel = {NSRC{FW'(1)}};
      expHit = '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        int idx;
        idx = findSrc(i);
        expSel[i*FW +: FW] = FW'(1) << idx;
        expHit[i] = (idx != 0);
      end
      if (bus.Advance_s1) begin
        pipe.push_front(bus.IssueDest_s1);
        pipe.delete(NSTAGE);
      end
      for (int k = 0; k < NSTAGE; k++) begin
        if (bus.Squash_s1[k]) begin
          grp_t g;
          g = pipe[k];
          for (int s = 0; s < NSLOT; s++) g[s*DW + SPEC_W] = 1'b0;
          pipe[k] = g;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      for (int i = 0; i < NSRC; i++) begin
        checks++;
        if (bus.BypassSel_v2[i*FW +: FW] !== expSel[i*FW +: FW] ||
            bus.BypassHit_v2[i] !== expHit[i]) begin
          errors++;
          $display("FAIL model_cmp src%0d t=%0t sel=%b hit=%b expected sel=%b hit=%b", i, $time,
                   bus.BypassSel_v2[i*FW +: FW], bus.BypassHit_v2[i],
                   expSel[i*FW +: FW], expHit[i]);
        end
      end
    end
  end

  task automatic checkLit(input string nm, input int i, input logic [FW-1:0] exp);
    checks++;
    if (bus.BypassSel_v2[i*FW +: FW] !== exp || bus.BypassHit_v2[i] !== ~exp[0]) begin
      errors++;
      $display("FAIL %s src%0d sel=%b hit=%b expected sel=%b hit=%b", nm, i,
               bus.BypassSel_v2[i*FW +: FW], bus.BypassHit_v2[i], exp, ~exp[0]);
    end
    checks++;
    if (expSel[i*FW +: FW] !== exp) begin
      errors++;
      $display("FAIL %s_model src%0d model=%b expected %b", nm, i, expSel[i*FW +: FW], exp);
    end
  endtask

  task automatic idle();
    bus.IssueDest_s1 = '0;
    bus.Advance_s1   = 1'b0;
    bus.Squash_s1    = '0;
    bus.SrcSpec_s1   = '0;
    bus.SrcValid_s1  = '0;
  endtask

  task automatic issue(input logic v0, input int sp0, input logic v1, input int sp1);
    bus.IssueDest_s1 = {v1, SPEC_W'(sp1), v0, SPEC_W'(sp0)};
    bus.Advance_s1   = 1'b1;
  endtask

  task automatic query(input int i, input int sp, input logic v);
    bus.SrcSpec_s1[i*SPEC_W +: SPEC_W] = SPEC_W'(sp);
    bus.SrcValid_s1[i] = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    chkEn = 1'b1;
    checkLit("reset_default", 0, 5'b00001);
    checkLit("reset_default", 3, 5'b00001);
    rst = 1'b0;

    // Single-stage hit
    issue(1, 5, 0, 0); step();
    idle(); query(0, 5, 1); step();
    checkLit("single_hit", 0, 5'b00010);

    // Youngest stage wins over older stage
    idle(); issue(0, 0, 1, 7); step();
    idle(); issue(1, 7, 0, 0); step();
    idle(); query(0, 7, 1); query(2, 7, 1); step();
    checkLit("youngest_wins", 0, 5'b00010);
    checkLit("youngest_wins", 2, 5'b00010);

    // Same-stage: higher slot wins
    idle(); issue(1, 9, 1, 9); step();
    idle(); query(0, 9, 1); step();
    checkLit("same_stage", 0, 5'b00100);

    // R0 never bypasses; invalid source never bypasses
    idle(); issue(1, 0, 0, 0); step();
    idle(); query(0, 0, 1); step();
    checkLit("r0", 0, 5'b00001);
    idle(); issue(1, 5, 0, 0); step();
    idle(); query(1, 5, 0); query(0, 5, 1); step();
    checkLit("src_invalid", 1, 5'b00001);
    checkLit("src_valid", 0, 5'b00010);

    // Stall holds stage 0, squash of stage 1 and of incoming issue
    idle(); issue(1, 3, 0, 0); step();
    idle(); query(0, 3, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      checkLit("stall_hold", 0, 5'b00010);
    end
    bus.Advance_s1 = 1'b1; bus.Squash_s1 = 2'b10; step();
    checkLit("pre_squash", 0, 5'b00010);
    idle(); query(0, 3, 1); step();
    checkLit("squash_stage1", 0, 5'b00001);
    idle(); issue(1, 4, 0, 0); bus.Squash_s1 = 2'b01; step();
    idle(); query(0, 4, 1); step();
    checkLit("squash_issue", 0, 5'b00001);

    // Asynchronous reset mid-run with live entries
    idle(); issue(1, 5, 0, 0); step();
    idle(); query(0, 5, 1); step();
    checkLit("pre_reset", 0, 5'b00010);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NSRC; i++) checkLit("async_reset", i, 5'b00001);
    @(negedge clk);
    rst = 1'b0;
    step();
    checkLit("post_reset", 0, 5'b00001);

    // Deterministic mixed traffic, checked every cycle against the model
    for (int n = 0; n < 40; n++) begin
      idle();
      bus.IssueDest_s1 = {((n % 3) != 1), SPEC_W'((n * 5) % 4), ((n % 2) == 0), SPEC_W'((n * 3) % 4)};
      bus.Advance_s1   = ((n % 4) != 3);
      bus.Squash_s1    = (n % 7 == 6) ? 2'b10 : ((n % 11 == 10) ? 2'b01 : 2'b00);
      for (int i = 0; i < NSRC; i++) query(i, (n + i) % 4, ((n + i) % 3) != 0);
      step();
    end

    idle(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
